// File: rtl/adc3wire_responder_if.sv
// rtl/adc3wire_responder_if.sv - register read/write bus of the 3-wire ADC responder
interface adc3wire_responder_if;
    logic [3:0]  rd_addr;
    logic [15:0] rd_data;
    logic        wr_valid;
    logic [3:0]  wr_addr;
    logic [15:0] wr_data;
    logic        frame_err;
    logic [7:0]  err_count;
    logic        busy;

    modport master (
        output rd_addr,
        input  rd_data, wr_valid, wr_addr, wr_data, frame_err, err_count, busy
    );

    modport slave (
        input  rd_addr,
        output rd_data, wr_valid, wr_addr, wr_data, frame_err, err_count, busy
    );
endinterface

// File: rtl/adc3wire_responder.sv
// rtl/adc3wire_responder.sv - 3-wire serial frame receiver into a 16x16 register file
// Optional header compare: define ADC3WIRE_RESP_HDR_CHECK_EN.
module adc3wire_responder #(
    parameter int          SYNC_STAGES = 2,
    parameter logic [11:0] HEADER      = 12'h001
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 adc3wire_clk,
    input  logic                 adc3wire_data,
    input  logic                 adc3wire_strobe,
    adc3wire_responder_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, SHIFT, CHECK} state_t;

    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0] clk_sync, data_sync, stb_sync;
    logic        clk_prev, stb_prev;
    logic        s_clk, s_data, s_stb;
    logic        ser_edge, stb_fall, stb_rise;

    logic [31:0] shreg;
    logic [5:0]  bit_cnt;
    logic        hdr_ok, accept;

    logic [15:0] regs [16];
    logic [15:0] rd_data_q, wr_data_q;
    logic [3:0]  wr_addr_q;
    logic        wr_valid_q, frame_err_q;
    logic [7:0]  err_count_q;

    assign s_clk    = clk_sync[SYNC_STAGES-1];
    assign s_data   = data_sync[SYNC_STAGES-1];
    assign s_stb    = stb_sync[SYNC_STAGES-1];
    assign ser_edge = s_clk & ~clk_prev;
    assign stb_fall = stb_prev & ~s_stb;
    assign stb_rise = ~stb_prev & s_stb;

`ifdef ADC3WIRE_RESP_HDR_CHECK_EN
    assign hdr_ok = (shreg[31:20] == HEADER);
`else
    logic unused_hdr;
    assign unused_hdr = &{1'b0, shreg[31:20]};
    assign hdr_ok     = 1'b1;
`endif

    assign accept = (bit_cnt == 6'd32) && hdr_ok;

    // Synchronizers idle high so a reset never fakes a serial edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_sync  <= '1;
            data_sync <= '1;
            stb_sync  <= '1;
            clk_prev  <= 1'b1;
            stb_prev  <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], adc3wire_clk};
            data_sync <= {data_sync[SYNC_STAGES-2:0], adc3wire_data};
            stb_sync  <= {stb_sync[SYNC_STAGES-2:0], adc3wire_strobe};
            clk_prev  <= s_clk;
            stb_prev  <= s_stb;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (stb_fall) state_d = SHIFT;
            SHIFT:   if (stb_rise) state_d = CHECK;
            CHECK:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg       <= '0;
            bit_cnt     <= '0;
            rd_data_q   <= '0;
            wr_valid_q  <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            frame_err_q <= 1'b0;
            err_count_q <= '0;
            for (int i = 0; i < 16; i++) regs[i] <= '0;
        end else begin
            wr_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            // Non-blocking read alongside the write gives read-before-write.
            rd_data_q   <= regs[bus.rd_addr];
            case (state_q)
                IDLE: begin
                    if (stb_fall) begin
                        shreg   <= '0;
                        bit_cnt <= '0;
                    end
                end
                SHIFT: begin
                    if (ser_edge) begin
                        shreg <= {shreg[30:0], s_data};
                        if (bit_cnt != 6'd33) bit_cnt <= bit_cnt + 6'd1;
                    end
                end
                CHECK: begin
                    if (accept) begin
                        wr_valid_q          <= 1'b1;
                        wr_addr_q           <= shreg[19:16];
                        wr_data_q           <= shreg[15:0];
                        regs[shreg[19:16]]  <= shreg[15:0];
                    end else begin
                        frame_err_q <= 1'b1;
                        if (err_count_q != 8'hFF) err_count_q <= err_count_q + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.rd_data   = rd_data_q;
    assign bus.wr_valid  = wr_valid_q;
    assign bus.wr_addr   = wr_addr_q;
    assign bus.wr_data   = wr_data_q;
    assign bus.frame_err = frame_err_q;
    assign bus.err_count = err_count_q;
    assign bus.busy      = (state_q != IDLE);
endmodule
